// File: rtl/player_death_ctrl.sv
// Player death / respawn sequencer: freezes play for a death animation, consumes a life,
// then either respawns the digger with a frame-counted invulnerability window or latches game over.
module player_death_ctrl #(
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 90
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playGame,
  input  logic       collision_monster,
  input  logic       collision_rock,
  input  logic       no_lives,
  output logic       player_died,
  output logic       freeze_game,
  output logic       respawn,
  output logic       invulnerable,
  output logic [2:0] death_anim_frame,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIVE     = 3'd1,
    DYING     = 3'd2,
    DIED      = 3'd3,
    CHECK     = 3'd4,
    RESPAWN   = 3'd5,
    INVULN    = 3'd6,
    GAME_OVER = 3'd7
  } state_t;

  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       player_died_d, freeze_game_d, respawn_d, invulnerable_d, game_over_d;
  logic [2:0] death_anim_frame_d;

  // Next-state and frame counter; dropping playGame overrides every other transition.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (!playGame) begin
      state_d     = IDLE;
      frame_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = ALIVE;
          frame_cnt_d = 8'd0;
        end
        ALIVE: begin
          if (collision_monster || collision_rock) begin
            state_d     = DYING;
            frame_cnt_d = 8'd0;
          end else begin
            state_d = ALIVE;
          end
        end
        DYING: begin
          if (startOfFrame && (frame_cnt_q == DEATH_LAST)) begin
            state_d     = DIED;
            frame_cnt_d = 8'd0;
          end else if (startOfFrame) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        DIED:    state_d = CHECK;
        CHECK:   state_d = no_lives ? GAME_OVER : RESPAWN;
        RESPAWN: begin
          state_d     = INVULN;
          frame_cnt_d = 8'd0;
        end
        INVULN: begin
          if (startOfFrame && (frame_cnt_q == INVULN_LAST)) begin
            state_d     = ALIVE;
            frame_cnt_d = 8'd0;
          end else if (startOfFrame) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        GAME_OVER: state_d = GAME_OVER;
        default: begin
          state_d     = IDLE;
          frame_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so the registered outputs track the state register exactly.
  always_comb begin
    player_died_d      = (state_d == DIED);
    respawn_d          = (state_d == RESPAWN);
    invulnerable_d     = (state_d == RESPAWN) || (state_d == INVULN);
    game_over_d        = (state_d == GAME_OVER);
    freeze_game_d      = (state_d == DYING) || (state_d == DIED) || (state_d == CHECK) ||
                         (state_d == RESPAWN) || (state_d == GAME_OVER);
    death_anim_frame_d = 3'd0;
    if (state_d == DYING) begin
      death_anim_frame_d = (frame_cnt_d[7:6] != 2'd0) ? 3'd7 : frame_cnt_d[5:3];
    end else begin
      death_anim_frame_d = 3'd0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q          <= IDLE;
      frame_cnt_q      <= 8'd0;
      player_died      <= 1'b0;
      freeze_game      <= 1'b0;
      respawn          <= 1'b0;
      invulnerable     <= 1'b0;
      death_anim_frame <= 3'd0;
      game_over        <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      player_died      <= player_died_d;
      freeze_game      <= freeze_game_d;
      respawn          <= respawn_d;
      invulnerable     <= invulnerable_d;
      death_anim_frame <= death_anim_frame_d;
      game_over        <= game_over_d;
    end
  end

endmodule

// File: tb/tb_player_death_ctrl.sv
// Directed self-checking bench for player_death_ctrl with DEATH_FRAMES=4, INVULN_FRAMES=3.
module tb_player_death_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, playGame, collision_monster, collision_rock, no_lives;
  logic       player_died, freeze_game, respawn, invulnerable, game_over;
  logic [2:0] death_anim_frame;

  int n_checks = 0;
  int n_fail   = 0;
  int died_cnt = 0;
  int resp_cnt = 0;

  // Output vector: [7] died [6] freeze [5] respawn [4] invuln [3:1] anim [0] game_over
  localparam logic [7:0] V_ZERO  = 8'b0000_0000;
  localparam logic [7:0] V_DYING = 8'b0100_0000;
  localparam logic [7:0] V_DIED  = 8'b1100_0000;
  localparam logic [7:0] V_CHECK = 8'b0100_0000;
  localparam logic [7:0] V_RESP  = 8'b0111_0000;
  localparam logic [7:0] V_INV   = 8'b0001_0000;
  localparam logic [7:0] V_GO    = 8'b0100_0001;

  logic [7:0] obs;
  assign obs = {player_died, freeze_game, respawn, invulnerable, death_anim_frame, game_over};

  player_death_ctrl #(.DEATH_FRAMES(4), .INVULN_FRAMES(3)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
    .collision_monster(collision_monster), .collision_rock(collision_rock), .no_lives(no_lives),
    .player_died(player_died), .freeze_game(freeze_game), .respawn(respawn),
    .invulnerable(invulnerable), .death_anim_frame(death_anim_frame), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled once per cycle on the inactive edge.
  always @(negedge clk) begin
    if (player_died) died_cnt <= died_cnt + 1;
    if (respawn)     resp_cnt <= resp_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sof_tick;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b0;
    collision_monster = 1'b0; collision_rock = 1'b0; no_lives = 1'b0;
    #2;
    check_eq("reset_outputs", {24'd0, obs}, {24'd0, V_ZERO});
    #10;
    resetN = 1'b1; playGame = 1'b1;

    // Normal death, with rock collisions held through the whole sequence
    tick();
    check_eq("t1_alive", {24'd0, obs}, {24'd0, V_ZERO});
    collision_monster = 1'b1;
    tick();
    collision_monster = 1'b0; collision_rock = 1'b1;
    check_eq("t1_dying_entry", {24'd0, obs}, {24'd0, V_DYING});
    for (int i = 0; i < 4; i++) begin
      sof_tick();
      check_eq($sformatf("t1_frame%0d", i), {24'd0, obs}, {24'd0, (i < 3) ? V_DYING : V_DIED});
    end
    tick();
    check_eq("t1_check", {24'd0, obs}, {24'd0, V_CHECK});
    tick();
    check_eq("t1_respawn", {24'd0, obs}, {24'd0, V_RESP});
    tick();
    check_eq("t1_invuln", {24'd0, obs}, {24'd0, V_INV});
    for (int i = 0; i < 3; i++) begin
      sof_tick();
      check_eq($sformatf("t1_inv_frame%0d", i), {24'd0, obs}, {24'd0, (i < 2) ? V_INV : V_ZERO});
    end
    collision_rock = 1'b0;
    tick(); tick();
    check_eq("t1_alive_again", {24'd0, obs}, {24'd0, V_ZERO});
    check_eq("t1_died_cnt", died_cnt, 1);
    check_eq("t1_resp_cnt", resp_cnt, 1);

    // Collision and frame pulse together, then last life
    collision_monster = 1'b1; startOfFrame = 1'b1;
    tick();
    collision_monster = 1'b0; startOfFrame = 1'b0;
    check_eq("t2_dying_entry", {24'd0, obs}, {24'd0, V_DYING});
    for (int i = 0; i < 4; i++) begin
      sof_tick();
      check_eq($sformatf("t2_frame%0d", i), {24'd0, obs}, {24'd0, (i < 3) ? V_DYING : V_DIED});
    end
    no_lives = 1'b1;
    tick();
    check_eq("t2_check", {24'd0, obs}, {24'd0, V_CHECK});
    tick();
    check_eq("t2_game_over", {24'd0, obs}, {24'd0, V_GO});
    collision_rock = 1'b1;
    for (int i = 0; i < 3; i++) sof_tick();
    collision_rock = 1'b0;
    check_eq("t2_game_over_held", {24'd0, obs}, {24'd0, V_GO});
    check_eq("t2_died_cnt", died_cnt, 2);
    check_eq("t2_no_respawn", resp_cnt, 1);
    playGame = 1'b0;
    tick();
    no_lives = 1'b0;
    check_eq("t2_idle", {24'd0, obs}, {24'd0, V_ZERO});

    // Abort mid-death by dropping playGame
    playGame = 1'b1;
    tick();
    collision_rock = 1'b1;
    tick();
    collision_rock = 1'b0;
    check_eq("t3_dying", {24'd0, obs}, {24'd0, V_DYING});
    sof_tick(); sof_tick();
    check_eq("t3_dying_2f", {24'd0, obs}, {24'd0, V_DYING});
    playGame = 1'b0;
    tick();
    check_eq("t3_abort_idle", {24'd0, obs}, {24'd0, V_ZERO});
    sof_tick(); sof_tick(); tick();
    check_eq("t3_still_idle", {24'd0, obs}, {24'd0, V_ZERO});
    check_eq("t3_died_cnt", died_cnt, 2);

    // Async reset in the middle of invulnerability
    playGame = 1'b1;
    tick();
    collision_monster = 1'b1;
    tick();
    collision_monster = 1'b0;
    for (int i = 0; i < 4; i++) sof_tick();
    tick(); tick(); tick();
    sof_tick();
    check_eq("t4_invuln_before_rst", {24'd0, obs}, {24'd0, V_INV});
    #3;
    resetN = 1'b0;
    #1;
    check_eq("t4_async_reset", {24'd0, obs}, {24'd0, V_ZERO});
    resetN = 1'b1;
    tick();
    check_eq("t4_after_release", {24'd0, obs}, {24'd0, V_ZERO});
    collision_monster = 1'b1;
    tick();
    collision_monster = 1'b0;
    check_eq("t4_alive_first_edge", {24'd0, obs}, {24'd0, V_DYING});
    check_eq("t4_died_cnt", died_cnt, 3);
    check_eq("t4_resp_cnt", resp_cnt, 2);
    playGame = 1'b0;
    tick();
    check_eq("t4_final_idle", {24'd0, obs}, {24'd0, V_ZERO});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
